// File: rtl/tse_reg_arbiter_pkg.sv
// Shared definitions for the TSE register-port arbiter: FSM state encoding,
// MAC register word offsets and command_config bit positions.
package tse_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam logic [7:0] COMMAND_CONFIG = 8'h02;
    localparam logic [7:0] MAC_0          = 8'h03;
    localparam logic [7:0] MAC_1          = 8'h04;
    localparam logic [7:0] FRM_LENGTH     = 8'h05;

    localparam int TX_ENA    = 32'd0;
    localparam int RX_ENA    = 32'd1;
    localparam int ETH_SPEED = 32'd3;
    localparam int PROMIS_EN = 32'd4;

endpackage

// File: rtl/tse_reg_arbiter_if.sv
// MAC register bus: the arbiter is master (drives address/data/strobes),
// the MAC is slave (returns read data and waitrequest).
interface tse_reg_arbiter_if;
    logic [7:0]  reg_addr;
    logic [31:0] reg_data_in;
    logic        reg_rd;
    logic        reg_wr;
    logic [31:0] reg_data_out;
    logic        reg_busy;

    modport master (
        output reg_addr, reg_data_in, reg_rd, reg_wr,
        input  reg_data_out, reg_busy
    );

    modport slave (
        input  reg_addr, reg_data_in, reg_rd, reg_wr,
        output reg_data_out, reg_busy
    );
endinterface

// File: rtl/tse_reg_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping, reported as one-hot grant plus binary index.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index,
    output logic            any
);

    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   index_s;
    logic            found_s;
    int              idx_v;

    // Scan requesters starting at ptr and stop at the first one asserted.
    always_comb begin
        grant_s = {NREQ{1'b0}};
        index_s = {IW{1'b0}};
        found_s = 1'b0;
        idx_v   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = (int'(ptr) + k) % NREQ;
            if (!found_s && req[idx_v]) begin
                found_s        = 1'b1;
                grant_s[idx_v] = 1'b1;
                index_s        = idx_v[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant = grant_s;
    assign index = index_s;
    assign any   = found_s;

endmodule

// File: rtl/tse_reg_arbiter.sv
// Arbitrates NREQ register-access requesters onto the single TSE MAC
// register port, one transaction at a time, with a busy timeout.
module tse_reg_arbiter
    import tse_reg_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_wr,
    input  logic [NREQ-1:0][7:0]  req_addr,
    input  logic [NREQ-1:0][31:0] req_wdata,
    output logic [NREQ-1:0]       req_ack,
    output logic                  req_err,
    output logic [31:0]           req_rdata,
    tse_reg_arbiter_if.master     reg_bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_RESP  = ST_RESP;

    logic [1:0]      state_r;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   win_idx_r;
    logic [NREQ-1:0] win_grant_r;
    logic            win_wr_r;
    logic [CW-1:0]   cnt_r;

    logic [7:0]      reg_addr_r;
    logic [31:0]     reg_data_in_r;
    logic            reg_rd_r;
    logic            reg_wr_r;
    logic [NREQ-1:0] req_ack_r;
    logic            req_err_r;
    logic [31:0]     req_rdata_r;

    logic [NREQ-1:0] pick_grant_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_any_s;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .index (pick_idx_s),
        .any   (pick_any_s)
    );

    // Transaction FSM; the bus strobes are registered at grant time so the
    // command appears on the MAC port the cycle after arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            ptr_r         <= {IW{1'b0}};
            win_idx_r     <= {IW{1'b0}};
            win_grant_r   <= {NREQ{1'b0}};
            win_wr_r      <= 1'b0;
            cnt_r         <= {CW{1'b0}};
            reg_addr_r    <= 8'd0;
            reg_data_in_r <= 32'd0;
            reg_rd_r      <= 1'b0;
            reg_wr_r      <= 1'b0;
            req_ack_r     <= {NREQ{1'b0}};
            req_err_r     <= 1'b0;
            req_rdata_r   <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    req_ack_r <= {NREQ{1'b0}};
                    req_err_r <= 1'b0;
                    if (pick_any_s) begin
                        win_idx_r     <= pick_idx_s;
                        win_grant_r   <= pick_grant_s;
                        win_wr_r      <= req_wr[pick_idx_s];
                        reg_addr_r    <= req_addr[pick_idx_s];
                        reg_data_in_r <= req_wdata[pick_idx_s];
                        reg_wr_r      <= req_wr[pick_idx_s];
                        reg_rd_r      <= ~req_wr[pick_idx_s];
                        cnt_r         <= {CW{1'b0}};
                        state_r       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!reg_bus.reg_busy) begin
                        reg_rd_r    <= 1'b0;
                        reg_wr_r    <= 1'b0;
                        req_ack_r   <= win_grant_r;
                        req_err_r   <= 1'b0;
                        req_rdata_r <= win_wr_r ? 32'd0 : reg_bus.reg_data_out;
                        state_r     <= S_RESP;
                    end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                        // This busy cycle is the TIMEOUT-th one: abort.
                        cnt_r       <= cnt_r + CW'(1);
                        reg_rd_r    <= 1'b0;
                        reg_wr_r    <= 1'b0;
                        req_ack_r   <= win_grant_r;
                        req_err_r   <= 1'b1;
                        req_rdata_r <= 32'd0;
                        state_r     <= S_RESP;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_RESP: begin
                    req_ack_r   <= {NREQ{1'b0}};
                    req_err_r   <= 1'b0;
                    req_rdata_r <= 32'd0;
                    ptr_r       <= (win_idx_r == IW'(NREQ - 1)) ? {IW{1'b0}}
                                                                : win_idx_r + IW'(1);
                    state_r     <= S_IDLE;
                end
                default: begin
                    reg_rd_r  <= 1'b0;
                    reg_wr_r  <= 1'b0;
                    req_ack_r <= {NREQ{1'b0}};
                    req_err_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

    assign reg_bus.reg_addr    = reg_addr_r;
    assign reg_bus.reg_data_in = reg_data_in_r;
    assign reg_bus.reg_rd      = reg_rd_r;
    assign reg_bus.reg_wr      = reg_wr_r;
    assign req_ack             = req_ack_r;
    assign req_err             = req_err_r;
    assign req_rdata           = req_rdata_r;

endmodule

// File: tb/tb_tse_reg_arbiter.sv
// Directed plus randomized bench for tse_reg_arbiter against a round-robin
// transaction model (winner, bus command, busy/timeout outcome, response).
module tb_tse_reg_arbiter;
    import tse_reg_pkg::*;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_wr;
    logic [NREQ-1:0][7:0]  req_addr;
    logic [NREQ-1:0][31:0] req_wdata;
    logic [NREQ-1:0]       req_ack;
    logic                  req_err;
    logic [31:0]           req_rdata;

    tse_reg_arbiter_if bus_if ();

    tse_reg_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .reg_bus   (bus_if.master)
    );

    int checks   = 0;
    int failures = 0;
    int ptr_m    = 0;
    int w        = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},    {29'd0, req_ack}, 32'd0);
        chk({tag, "_err"},    {31'd0, req_err}, 32'd0);
        chk({tag, "_rdata"},  req_rdata, 32'd0);
        chk({tag, "_rd"},     {31'd0, bus_if.reg_rd}, 32'd0);
        chk({tag, "_wr"},     {31'd0, bus_if.reg_wr}, 32'd0);
        chk({tag, "_addr"},   {24'd0, bus_if.reg_addr}, 32'd0);
        chk({tag, "_datain"}, bus_if.reg_data_in, 32'd0);
    endtask

    // Called at an IDLE-cycle negedge with requests already driven; returns at
    // the following IDLE-cycle negedge, so back-to-back calls are 3 cycles apart.
    task automatic txn(input int busy_cycles, input logic [31:0] rd_val,
                       input bit keep, input bit drop_early, output int win);
        logic        exp_wr;
        logic [7:0]  exp_addr;
        logic [31:0] exp_wd;
        bit          tmo;
        int          n_issue;
        win = pick(req_valid, ptr_m);
        if (win < 0) begin
            chk("model_no_request", {29'd0, req_valid}, 32'd1);
            return;
        end
        exp_wr   = req_wr[win];
        exp_addr = req_addr[win];
        exp_wd   = req_wdata[win];
        tmo      = (busy_cycles >= TIMEOUT);
        n_issue  = tmo ? TIMEOUT : busy_cycles + 1;
        @(negedge clk);
        for (int i = 0; i < n_issue; i++) begin
            chk("bus_wr",    {31'd0, bus_if.reg_wr}, {31'd0, exp_wr});
            chk("bus_rd",    {31'd0, bus_if.reg_rd}, {31'd0, ~exp_wr});
            chk("bus_addr",  {24'd0, bus_if.reg_addr}, {24'd0, exp_addr});
            if (exp_wr) chk("bus_datain", bus_if.reg_data_in, exp_wd);
            chk("ack_during_issue", {29'd0, req_ack}, 32'd0);
            if (drop_early && i == 0) req_valid[win] = 1'b0;
            bus_if.reg_busy     = (i < busy_cycles);
            bus_if.reg_data_out = (i < busy_cycles) ? $urandom : rd_val;
            @(negedge clk);
        end
        bus_if.reg_busy     = 1'b0;
        bus_if.reg_data_out = $urandom;
        chk("resp_rd",    {31'd0, bus_if.reg_rd}, 32'd0);
        chk("resp_wr",    {31'd0, bus_if.reg_wr}, 32'd0);
        chk("resp_ack",   {29'd0, req_ack}, 32'd1 << win);
        chk("resp_err",   {31'd0, req_err}, {31'd0, tmo});
        chk("resp_rdata", req_rdata, (tmo || exp_wr) ? 32'd0 : rd_val);
        ptr_m = (win + 1) % NREQ;
        if (!keep) req_valid[win] = 1'b0;
        @(negedge clk);
        chk("idle_ack", {29'd0, req_ack}, 32'd0);
        chk("idle_err", {31'd0, req_err}, 32'd0);
    endtask

    task automatic set_req(input int r, input logic wr, input logic [7:0] a, input logic [31:0] d);
        req_valid[r] = 1'b1;
        req_wr[r]    = wr;
        req_addr[r]  = a;
        req_wdata[r] = d;
    endtask

    initial begin
        rst_n               = 1'b0;
        req_valid           = '0;
        req_wr              = '0;
        req_addr            = '0;
        req_wdata           = '0;
        bus_if.reg_busy     = 1'b0;
        bus_if.reg_data_out = 32'd0;

        // Reset state, with all three requesting continuously from reset.
        set_req(0, 1'b1, MAC_0, 32'h1111_0000);
        set_req(1, 1'b0, COMMAND_CONFIG, 32'd0);
        set_req(2, 1'b1, FRM_LENGTH, 32'h0000_05EE);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        ptr_m = 0;

        // Round-robin order 0,1,2,0,1,2 with acks 3 cycles apart.
        for (int g = 0; g < 6; g++) begin
            txn(0, 32'hA5A5_0000 + 32'(g), 1'b1, 1'b0, w);
            chk("rr_order_ack", {29'd0, req_ack}, 32'd0);
        end
        req_valid = '0;
        @(negedge clk);

        // Requester 0 write to MAC_0, no wait state.
        set_req(0, 1'b1, MAC_0, 32'h1723_1C00);
        txn(0, 32'hDEAD_BEEF, 1'b0, 1'b0, w);

        // Requester 1 read of command_config with 5 busy cycles.
        set_req(1, 1'b0, COMMAND_CONFIG, 32'd0);
        txn(5, 32'h0080_2220, 1'b0, 1'b0, w);

        // Granted requester withdraws its request; ack must still arrive.
        set_req(2, 1'b0, MAC_1, 32'd0);
        txn(2, 32'h0000_1234, 1'b0, 1'b1, w);

        // Busy stuck high: abort with error, then the next requester is served.
        set_req(0, 1'b1, COMMAND_CONFIG, 32'h0000_0003);
        set_req(2, 1'b1, FRM_LENGTH, 32'h0000_0600);
        txn(TIMEOUT + 10, 32'd0, 1'b0, 1'b0, w);
        txn(0, 32'd0, 1'b0, 1'b0, w);

        // Reset in the middle of ISSUE: outputs clear at once, no ack follows.
        set_req(1, 1'b1, MAC_1, 32'h0000_ABCD);
        @(negedge clk);
        chk("pre_reset_wr", {31'd0, bus_if.reg_wr}, 32'd1);
        bus_if.reg_busy = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        bus_if.reg_busy = 1'b0;
        @(negedge clk);
        chk("reset_no_ack", {29'd0, req_ack}, 32'd0);
        rst_n = 1'b1;
        ptr_m = 0;
        set_req(0, 1'b0, COMMAND_CONFIG, 32'd0);
        set_req(2, 1'b0, MAC_0, 32'd0);
        txn(1, 32'h0000_0042, 1'b0, 1'b0, w);
        chk("post_reset_winner", 32'(w), 32'd0);

        // Randomized traffic; un-served requests persist into later rounds.
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!req_valid[r] && ($urandom_range(0, 1) == 1))
                    set_req(r, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
            end
            if (req_valid == '0)
                set_req(int'($urandom_range(0, NREQ - 1)), 1'b0, 8'($urandom), $urandom);
            txn(($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : int'($urandom_range(0, 3)),
                $urandom, 1'b0, 1'b0, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
